// File: rtl/mem_request_queue_pkg.sv
// Shared types and constants for the memory request queue and the processor traffic generator.
package mem_request_queue_pkg;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 8;
    localparam int MEM_WORDS = 1 << ADDR_W;

    typedef struct packed {
        logic              rwb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;
endpackage

// File: rtl/mem_request_queue_req_fifo.sv
// Request FIFO: power-of-two depth, wraparound pointers, accepts a push while full if a pop coincides.
module mem_request_queue_req_fifo
    import mem_request_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  req_t                   wdata,
    output req_t                   head,
    output req_t                   head_next,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_nx;
    logic [OCC_W-1:0]        count_q, count_d;
    req_t [DEPTH-1:0]        buf_q, buf_d;
    logic                    push_ok;
    logic                    pop_ok;

    assign full      = (count_q == OCC_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign rd_ptr_nx = rd_ptr_q + PTR_W'(1);
    assign head      = buf_q[rd_ptr_q];
    assign head_next = buf_q[rd_ptr_nx];

    // A full FIFO still takes the new request when the head leaves on the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_nx            : rd_ptr_q;
        buf_d    = buf_q;
        if (push_ok) begin
            buf_d[wr_ptr_q] = wdata;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end
endmodule

// File: rtl/mem_request_queue.sv
// Memory-side request consumer: queues {RWB, Address, Data} requests and serves them in order
// against a 64x8 memory with fixed access latency, reporting read results and saturating counters.
module mem_request_queue
    import mem_request_queue_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int MEM_LATENCY = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              RWB,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data,
    output logic              full,
    output logic              busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int WAIT_W = $clog2(MEM_LATENCY + 1);
    localparam int OCC_W  = $clog2(DEPTH) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_LATENCY - 1);

    state_t                            state_q, state_d;
    logic [WAIT_W-1:0]                 wait_q, wait_d;
    req_t                              cur_q, cur_d;
    logic                              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]                 rd_data_q, rd_data_d;
    logic [ADDR_W-1:0]                 rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]                  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]                  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]                  drop_cnt_q, drop_cnt_d;
    logic [MEM_WORDS-1:0][DATA_W-1:0]  mem_q, mem_d;

    req_t              req_in;
    req_t              fifo_head;
    req_t              fifo_head_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OCC_W-1:0]  fifo_count;
    logic              pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign req_in = '{rwb: RWB, addr: Address, data: Data};

    mem_request_queue_req_fifo #(
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid),
        .pop       (pop),
        .wdata     (req_in),
        .head      (fifo_head),
        .head_next (fifo_head_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        cur_d      = cur_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        drop_cnt_d = drop_cnt_q;
        mem_d      = mem_q;
        pop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ACCESS;
                    cur_d   = fifo_head;
                    wait_d  = WAIT_LOAD;
                end
            end
            ACCESS: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else begin
                    pop = 1'b1;
                    if (cur_q.rwb) begin
                        rd_data_d  = mem_q[cur_q.addr];
                        rd_addr_d  = cur_q.addr;
                        rd_valid_d = 1'b1;
                        rd_cnt_d   = sat_inc(rd_cnt_q);
                    end else begin
                        mem_d[cur_q.addr] = cur_q.data;
                        wr_cnt_d          = sat_inc(wr_cnt_q);
                    end
                    // A request pushed on this same edge is not visible yet; it is picked up from IDLE.
                    if (fifo_count > OCC_W'(1)) begin
                        cur_d  = fifo_head_next;
                        wait_d = WAIT_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (req_valid && fifo_full && !pop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            drop_cnt_q <= '0;
            mem_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            mem_q      <= mem_d;
        end
    end

    always_ff @(posedge clk) begin
        cur_q <= cur_d;
    end

    assign full     = fifo_full;
    assign busy     = (state_q == ACCESS) || !fifo_empty;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_addr  = rd_addr_q;
    assign rd_cnt   = rd_cnt_q;
    assign wr_cnt   = wr_cnt_q;
    assign drop_cnt = drop_cnt_q;
endmodule

// File: doc/mem_request_queue.md
# mem_request_queue

Memory-side consumer of the processor traffic generator's request stream. Accepts one {RWB, Address, Data} request per cycle into a small FIFO. Serves requests in order against an internal 64x8 data memory with a fixed multi-cycle access latency. Returns read data with a valid strobe and keeps saturating read, write and dropped-request counters for the bench.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- MEM_LATENCY, 3: cycles per memory access; ≥1.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present this cycle; top level drives it as ~start.
- RWB  in  1  1 = read, 0 = write.
- Address  in  6  word address.
- Data  in  8  write data; ignored for reads.
- full  out  1  FIFO holds DEPTH entries.
- busy  out  1  FSM in ACCESS, or FIFO non-empty.
- rd_valid  out  1  one-cycle strobe; rd_data/rd_addr valid.
- rd_data  out  8  read result.
- rd_addr  out  6  address of the read result.
- rd_cnt  out  CNT_W  completed reads.
- wr_cnt  out  CNT_W  completed writes.
- drop_cnt  out  CNT_W  requests refused because the FIFO was full.

## Operation
- Push: at a rising edge with req_valid=1, the request is accepted unless the FIFO is full and no pop occurs that edge.
  - A refused request increments drop_cnt and is otherwise lost.
  - There is no back-pressure, because the producer cannot stall.
- Push when full with a simultaneous pop is accepted; occupancy stays DEPTH.
- Push and pop on an empty FIFO are not bypassed: a request must sit at least one cycle in the FIFO.
- Pointers wrap modulo DEPTH. Occupancy is tracked with a (log2(DEPTH)+1)-bit count.
- FSM states:
  - IDLE: FIFO non-empty → ACCESS, latch the head entry, load the wait counter with MEM_LATENCY-1.
  - ACCESS, counter ≠ 0: decrement.
  - ACCESS, counter = 0: perform the operation and pop the head.
    - Write: mem[addr] <= data, wr_cnt++.
    - Read: rd_data <= mem[addr], rd_addr <= addr, rd_valid <= 1, rd_cnt++.
    - Next state: if the FIFO still holds entries after the pop, reload and stay in ACCESS (back-to-back service); otherwise go to IDLE.
- Requests complete strictly in FIFO order. A read after a write to the same address returns the written value.
- Counters saturate at all-ones and do not wrap.
- Memory contents are cleared to 0 by reset.

## Timing
- Reset values (asynchronous, immediate):
  - FIFO empty; FSM in IDLE.
  - full=0, busy=0, rd_valid=0, rd_data=0, rd_addr=0.
  - All counters 0; all memory words 0.
- Reset mid-access: the in-flight request and all queued requests are discarded. No rd_valid is produced and no counter is incremented.
- Latency, request pushed at edge E into an idle, empty block:
  - ACCESS is entered at E+1.
  - The operation completes at edge E+1+MEM_LATENCY.
  - For a read, rd_valid is high for the cycle following that edge.
- Sustained throughput is one request per MEM_LATENCY cycles. With the producer issuing every cycle and MEM_LATENCY>1, the FIFO fills and drops accumulate.
- full and busy are registered-state derived. They are valid in the cycle after the edge that changed the state.
- rd_valid is high for exactly one cycle per read. rd_data and rd_addr hold their values until the next read completes.

## Structure
- Shared package holds:
  - request typedef (rwb, addr[5:0], data[7:0]);
  - FSM state enum {IDLE, ACCESS};
  - ADDR_W=6 and DATA_W=8 constants, shared with the processor block.
- One sub-module: req_fifo (DEPTH, request-wide). It has push/pop/full/empty and wraparound pointers.
- The FSM, memory array and counters live in the top module.

## Test plan
- Single write then read, MEM_LATENCY=3:
  - Stimulus: write 0xA5 to address 0x12, then an idle cycle, then a read of 0x12.
  - Required: rd_valid once with rd_data=0xA5 and rd_addr=0x12; wr_cnt=1, rd_cnt=1.
- Read of an untouched location after reset:
  - Stimulus: read address 0x3F.
  - Required: rd_data=0x00.
- Overflow, DEPTH=4, MEM_LATENCY=3:
  - Stimulus: 10 consecutive writes, one per cycle.
  - Required: drop_cnt = 10 minus accepted. The bench checks the value against the computed occupancy. Only accepted addresses change in memory.
- Full with simultaneous pop:
  - Stimulus: push in the same cycle a pop completes while full.
  - Required: the request is accepted, drop_cnt is unchanged, full stays 1.
- Reset mid-access:
  - Stimulus: assert rst_n=0 while in ACCESS with 3 queued requests.
  - Required: immediate busy=0, full=0, counters 0; no rd_valid after release.
- Counter saturation, CNT_W=4:
  - Stimulus: 20 completed writes.
  - Required: wr_cnt=4'hF.
